serial_match_sched: RTL and testbench
=====================================

# serial_match_sched

Round-robin scheduler that shares one serial 1101 Moore sequence detector among NREQ requesters. Each requester submits a WORD_W-bit word. The block serialises the word MSB-first into the detector and counts the overlapping 1101 matches the detector reports. It then zero-flushes the detector back to its idle state and returns the match count tagged with the requester ID. The block sits between the requesting units and the external detector instance, which shares clk and n_rst with this block.

## Interface
- NREQ, 4, number of requesters (≥2)
- WORD_W, 8, word width in bits (≥4)
- IDW, $clog2(NREQ), requester ID width
- CW, $clog2(WORD_W+1), match count width
- clk  in  1  clock; all state updates on the rising edge
- n_rst  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester request level; held with its word until granted
- word_in  in  NREQ*WORD_W  requester r's word in bits [r*WORD_W +: WORD_W]
- grant  out  NREQ  one-hot, single-cycle pulse; the word is captured this cycle
- det_i  out  1  serial bit to the detector
- det_o  in  1  detector Moore output; 1 = state RCV1101
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  single-cycle result strobe
- done_id  out  IDW  ID of the finished requester; holds until the next done
- match_cnt  out  CW  matches counted in the finished word; holds until the next done

## Operation
- The FSM has five states: IDLE, SHIFT, DRAIN, FLUSH, REPORT.
- **IDLE:** det_i=0.
  - If any req bit is set, pick the winner by round-robin: search from ptr+1 (mod NREQ) upward.
  - In the same cycle: assert grant[winner], load the shift register with the winner's word, store the winner's ID, set ptr=winner, clear the counter, and go to SHIFT with bit index k=0.
  - With no request, stay in IDLE.
- **SHIFT (k=0..WORD_W-1):** det_i = shreg[WORD_W-1-k].
  - For k≥1, if det_o=1, increment the counter. This counts the match completed by bit k-1.
  - At k=WORD_W-1, go to DRAIN.
- **DRAIN:** det_i=0. If det_o=1, increment the counter (this catches a match on the last bit). Go to FLUSH.
- **FLUSH:** det_i=0. Go to REPORT.
  - Two consecutive zeros return the detector to WAITING from any state, so det_o=0 at the next word's k=0.
- **REPORT:** det_i=0.
  - Assert done for one cycle.
  - Drive done_id and match_cnt from the stored ID and counter.
  - Go to IDLE.
- **Matches:** matches may overlap, per the detector's transition RCV1101 -1-> RCV11.
- **Counter:** CW bits wide; it cannot saturate within one word.
- **Requests while busy:** req is ignored outside IDLE. Arbitration happens only in IDLE, so the order of pending requests is preserved by the pointer.
- **grant:** never asserted in any state other than IDLE.
- **det_o outside SHIFT/DRAIN:** ignored.
- **Reset values:** state=IDLE; ptr=NREQ-1, so requester 0 has priority first; grant=0, det_i=0, busy=0, done=0, done_id=0, match_cnt=0, counter=0.
- **Reset mid-job:** the job is abandoned without a done pulse. The detector resets on the same n_rst, so no flush is needed.

## Timing
- grant at cycle G, SHIFT over G+1..G+WORD_W, DRAIN at G+WORD_W+1, FLUSH at G+WORD_W+2, done at G+WORD_W+3.
- The earliest next grant is G+WORD_W+4. Throughput is one word per WORD_W+4 cycles (12 for the default WORD_W=8).
- Detector latency is 1 cycle: det_i applied in cycle t appears on det_o in cycle t+1.
- The requester must deassert req in the cycle after its grant, or that is treated as a new request.
- busy is high from G+1 through the REPORT cycle inclusive.
- Registered outputs: grant, det_i, busy, done, done_id, match_cnt.

## Test plan
- **Single request:** after reset, req=0001 with word0=8'b1101_1010.
  - Expected: grant=0001 for one cycle; det_i sequence 1,1,0,1,1,0,1,0; done 11 cycles after grant (G+WORD_W+3) with done_id=0 and match_cnt=2.
- **Overlap and edge matches:** run the words 8'b0110_1101, 8'b1101_0000, 8'b0000_1101 and 8'b1111_1111.
  - Expected match_cnt: 2, 1, 1 and 0 respectively.
  - This checks the last-bit DRAIN capture and that the flush leaves no stale match.
- **Round-robin:** hold req=1111 continuously, reasserting each requester after its grant.
  - Expected: grants in ID order 0,1,2,3,0; grant spacing exactly 12 cycles; done_id follows the same order.
- **Pointer skip:** after requester 1 is served, raise req=1001.
  - Expected: next grant goes to 3, then to 0.
- **Request during busy:** raise req[2] mid-SHIFT.
  - Expected: no grant until IDLE; then grant=0100 in the cycle after REPORT.
- **Reset mid-job:** pull n_rst low at SHIFT k=4, then release it and request word 8'b1101_0000.
  - Expected during reset: all outputs 0 and no done pulse.
  - Expected after release: the first grant goes to the lowest requesting ID, and match_cnt=1.

Source files
------------

// File: rtl/serial_match_sched_if.sv
// Requester / detector bundle for serial_match_sched. The slave modport is the
// scheduler's view; the master modport is the requesters-plus-detector side.
interface serial_match_sched_if #(
  parameter int NREQ   = 4,
  parameter int WORD_W = 8,
  parameter int IDW    = $clog2(NREQ),
  parameter int CW     = $clog2(WORD_W + 1)
);
  logic [NREQ-1:0]        req;
  logic [NREQ*WORD_W-1:0] word_in;
  logic [NREQ-1:0]        grant;
  logic                   det_i;
  logic                   det_o;
  logic                   busy;
  logic                   done;
  logic [IDW-1:0]         done_id;
  logic [CW-1:0]          match_cnt;

  modport master (
    output req, word_in, det_o,
    input  grant, det_i, busy, done, done_id, match_cnt
  );

  modport slave (
    input  req, word_in, det_o,
    output grant, det_i, busy, done, done_id, match_cnt
  );
endinterface

// File: rtl/serial_match_sched.sv
// Round-robin scheduler that serialises requester words into a shared 1101
// Moore detector, counts its matches and returns the count tagged with the ID.
module serial_match_sched #(
  parameter int NREQ   = 4,
  parameter int WORD_W = 8,
  parameter int IDW    = $clog2(NREQ),
  parameter int CW     = $clog2(WORD_W + 1)
) (
  input  logic                clk,
  input  logic                n_rst,
  serial_match_sched_if.slave bus
);

  localparam int KW = $clog2(WORD_W);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SHIFT  = 3'd1;
  localparam logic [2:0] DRAIN  = 3'd2;
  localparam logic [2:0] FLUSH  = 3'd3;
  localparam logic [2:0] REPORT = 3'd4;

  localparam logic [KW-1:0]   K_LAST  = KW'(WORD_W - 1);
  localparam logic [KW-1:0]   K_TWO   = KW'(2);
  localparam logic [KW-1:0]   K_ONE   = KW'(1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [IDW-1:0]  PTR_RST = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

  logic [2:0]        state_r;
  logic [IDW-1:0]    ptr_r;
  logic [IDW-1:0]    id_r;
  logic [WORD_W-1:0] shreg_r;
  logic [KW-1:0]     k_r;
  logic [CW-1:0]     cnt_r;

  logic [NREQ-1:0]   grant_r;
  logic              det_i_r;
  logic              busy_r;
  logic              done_r;
  logic [IDW-1:0]    done_id_r;
  logic [CW-1:0]     match_cnt_r;

  logic              win_found_s;
  logic [IDW-1:0]    win_id_s;
  logic [IDW-1:0]    cand_s;
  logic              count_en_s;
  logic [WORD_W-1:0] words_s [NREQ];

  assign bus.grant     = grant_r;
  assign bus.det_i     = det_i_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.done_id   = done_id_r;
  assign bus.match_cnt = match_cnt_r;

  for (genvar r = 0; r < NREQ; r++) begin : g_words
    assign words_s[r] = bus.word_in[r*WORD_W +: WORD_W];
  end

  // Round-robin search starting just above the last winner.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = {IDW{1'b0}};
    cand_s      = {IDW{1'b0}};
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = IDW'((int'(ptr_r) + i) % NREQ);
      if (!win_found_s && bus.req[cand_s]) begin
        win_found_s = 1'b1;
        win_id_s    = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Outputs are registered, so state_r runs one cycle ahead of what the pins
  // show; det_o therefore reflects the bit state_r issued two cycles earlier.
  always_comb begin
    count_en_s = 1'b0;
    if (bus.det_o) begin
      case (state_r)
        SHIFT:   count_en_s = (k_r >= K_TWO);
        DRAIN:   count_en_s = 1'b1;
        FLUSH:   count_en_s = 1'b1;
        default: count_en_s = 1'b0;
      endcase
    end else begin
      count_en_s = 1'b0;
    end
  end

  // Scheduler FSM, match counter and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r     <= IDLE;
      ptr_r       <= PTR_RST;
      id_r        <= {IDW{1'b0}};
      shreg_r     <= {WORD_W{1'b0}};
      k_r         <= {KW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      grant_r     <= {NREQ{1'b0}};
      det_i_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      done_id_r   <= {IDW{1'b0}};
      match_cnt_r <= {CW{1'b0}};
    end else begin
      grant_r <= {NREQ{1'b0}};
      det_i_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= (state_r != IDLE);
      if (count_en_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      case (state_r)
        IDLE: begin
          if (win_found_s) begin
            grant_r <= GNT_ONE << win_id_s;
            shreg_r <= words_s[win_id_s];
            id_r    <= win_id_s;
            ptr_r   <= win_id_s;
            cnt_r   <= {CW{1'b0}};
            k_r     <= {KW{1'b0}};
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          det_i_r <= shreg_r[WORD_W-1];
          shreg_r <= shreg_r << 1;
          k_r     <= k_r + K_ONE;
          if (k_r == K_LAST) begin
            state_r <= DRAIN;
          end else begin
            state_r <= SHIFT;
          end
        end
        DRAIN:  state_r <= FLUSH;
        FLUSH:  state_r <= REPORT;
        REPORT: begin
          done_r      <= 1'b1;
          done_id_r   <= id_r;
          match_cnt_r <= cnt_r;
          state_r     <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_match_sched.sv
// Directed bench for serial_match_sched with a behavioural 1101 Moore detector
// on the det_i/det_o loop; expected counts are worked out by hand.
module tb_serial_match_sched;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;
  logic [2:0] dstate;

  serial_match_sched_if #(.NREQ(4), .WORD_W(8)) bus ();

  serial_match_sched #(.NREQ(4), .WORD_W(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Detector: 0 WAITING, 1 RCV1, 2 RCV11, 3 RCV110, 4 RCV1101
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dstate <= 3'd0;
    end else begin
      case (dstate)
        3'd0:    dstate <= bus.det_i ? 3'd1 : 3'd0;
        3'd1:    dstate <= bus.det_i ? 3'd2 : 3'd0;
        3'd2:    dstate <= bus.det_i ? 3'd2 : 3'd3;
        3'd3:    dstate <= bus.det_i ? 3'd4 : 3'd0;
        3'd4:    dstate <= bus.det_i ? 3'd2 : 3'd0;
        default: dstate <= 3'd0;
      endcase
    end
  end
  assign bus.det_o = (dstate == 3'd4);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "/grant"}, 32'(bus.grant), 32'd0);
    check({tag, "/det_i"}, 32'(bus.det_i), 32'd0);
    check({tag, "/busy"}, 32'(bus.busy), 32'd0);
    check({tag, "/done"}, 32'(bus.done), 32'd0);
    check({tag, "/done_id"}, 32'(bus.done_id), 32'd0);
    check({tag, "/match_cnt"}, 32'(bus.match_cnt), 32'd0);
  endtask

  task automatic set_word(input int id, input logic [7:0] w);
    bus.word_in[id*8 +: 8] = w;
  endtask

  // Waits (bounded) for a grant, then follows the job through to G+12.
  task automatic do_job(input string tag, input int id, input logic [7:0] w,
                        input int exp_cnt, input logic [3:0] drop,
                        input logic [3:0] raise, input int exp_wait);
    int n;
    n = 0;
    while (bus.grant === 4'b0000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/grant"}, 32'(bus.grant), 32'(4'b0001 << id));
    check({tag, "/busy_at_grant"}, 32'(bus.busy), 32'd0);
    if (exp_wait >= 0) check({tag, "/grant_wait"}, 32'(n), 32'(exp_wait));
    bus.req = bus.req & ~drop;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 3) bus.req = bus.req | raise;
      check({tag, "/det_i"}, 32'(bus.det_i), 32'(w[7-k]));
      check({tag, "/busy"}, 32'(bus.busy), 32'd1);
      check({tag, "/grant_busy"}, 32'(bus.grant), 32'd0);
    end
    @(negedge clk);
    check({tag, "/drain_det_i"}, 32'(bus.det_i), 32'd0);
    @(negedge clk);
    check({tag, "/flush_det_i"}, 32'(bus.det_i), 32'd0);
    check({tag, "/early_done"}, 32'(bus.done), 32'd0);
    @(negedge clk);
    check({tag, "/done"}, 32'(bus.done), 32'd1);
    check({tag, "/done_id"}, 32'(bus.done_id), 32'(id));
    check({tag, "/match_cnt"}, 32'(bus.match_cnt), 32'(exp_cnt));
    check({tag, "/busy_report"}, 32'(bus.busy), 32'd1);
    check({tag, "/grant_report"}, 32'(bus.grant), 32'd0);
    @(negedge clk);
    check({tag, "/done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "/busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, "/done_id_hold"}, 32'(bus.done_id), 32'(id));
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    n_rst = 1'b0;
    bus.req = 4'b0000;
    bus.word_in = 32'h0000_0000;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    n_rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // Single request; done 11 cycles after grant.
    set_word(0, 8'b1101_1010);
    bus.req = 4'b0001;
    do_job("single", 0, 8'b1101_1010, 2, 4'b0001, 4'b0000, 1);

    // Overlap and edge matches through requester 0.
    set_word(0, 8'b0110_1101); bus.req = 4'b0001;
    do_job("overlap", 0, 8'b0110_1101, 2, 4'b0001, 4'b0000, 1);
    set_word(0, 8'b1101_0000); bus.req = 4'b0001;
    do_job("first4", 0, 8'b1101_0000, 1, 4'b0001, 4'b0000, 1);
    set_word(0, 8'b0000_1101); bus.req = 4'b0001;
    do_job("last_bit", 0, 8'b0000_1101, 1, 4'b0001, 4'b0000, 1);
    set_word(0, 8'b1111_1111); bus.req = 4'b0001;
    do_job("all_ones", 0, 8'b1111_1111, 0, 4'b0001, 4'b0000, 1);

    // Pointer skip: serve 1, then 1001 goes to 3 then 0.
    set_word(1, 8'b1111_1111); bus.req = 4'b0010;
    do_job("serve1", 1, 8'b1111_1111, 0, 4'b0010, 4'b0000, 1);
    set_word(3, 8'b0000_1101); set_word(0, 8'b1101_1010);
    bus.req = 4'b1001;
    do_job("skip_to3", 3, 8'b0000_1101, 1, 4'b1000, 4'b0000, 1);
    do_job("skip_to0", 0, 8'b1101_1010, 2, 4'b0001, 4'b0000, 0);

    // Request during busy: req[2] raised mid-SHIFT, granted right after REPORT.
    set_word(1, 8'b1011_0110); set_word(2, 8'b0110_1101);
    bus.req = 4'b0010;
    do_job("busy_req1", 1, 8'b1011_0110, 1, 4'b0010, 4'b0100, 1);
    do_job("busy_req2", 2, 8'b0110_1101, 2, 4'b0100, 4'b0000, 0);

    // Move the pointer to 3, then hold req=1111 for 0,1,2,3,0 at 12-cycle spacing.
    bus.req = 4'b1000;
    do_job("pre_rr", 3, 8'b0000_1101, 1, 4'b1000, 4'b0000, 1);
    set_word(0, 8'b1101_1010); set_word(1, 8'b0110_1101);
    set_word(2, 8'b1101_0000); set_word(3, 8'b0000_1101);
    bus.req = 4'b1111;
    do_job("rr0", 0, 8'b1101_1010, 2, 4'b0000, 4'b0000, 1);
    do_job("rr1", 1, 8'b0110_1101, 2, 4'b0000, 4'b0000, 0);
    do_job("rr2", 2, 8'b1101_0000, 1, 4'b0000, 4'b0000, 0);
    do_job("rr3", 3, 8'b0000_1101, 1, 4'b0000, 4'b0000, 0);
    do_job("rr0b", 0, 8'b1101_1010, 2, 4'b1111, 4'b0000, 0);

    // Reset mid-job at SHIFT k=4.
    set_word(0, 8'b1101_1010);
    bus.req = 4'b0001;
    n = 0;
    while (bus.grant === 4'b0000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_job/grant", 32'(bus.grant), 32'd1);
    bus.req = 4'b0000;
    repeat (5) @(negedge clk);
    check("rst_job/k4_det_i", 32'(bus.det_i), 32'd1);
    #1 n_rst = 1'b0;
    #1 check_idle_outputs("mid_reset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle_outputs("in_reset");
    end
    n_rst = 1'b1;
    set_word(1, 8'b1101_0000); set_word(2, 8'b1111_1111);
    bus.req = 4'b0110;
    do_job("post_reset", 1, 8'b1101_0000, 1, 4'b0110, 4'b0000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
